// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and helpers for the seven-segment scan driver
package seg_pkg;

    // Hex glyphs, bit order {g,f,e,d,c,b,a}, segment-on = 1.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Slot length must split evenly into 2^bright_bits PWM units.
    function automatic bit params_legal(input int num_digits, input int refresh_div,
                                        input int bright_bits);
        return (num_digits >= 1) && (num_digits <= 16) && (bright_bits >= 1) &&
               (refresh_div >= (1 << bright_bits)) &&
               ((refresh_div % (1 << bright_bits)) == 0);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble to seven-segment decoder
// Ports:
//   nibble : 4-bit hex value
//   seg    : {g,f,e,d,c,b,a}, 1 = segment on
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with frame-synchronous updates
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   digits_in           : packed nibbles, digit i at [4i+3:4i], top digit leftmost
//   dp_in, blank_in     : per-digit decimal point and force-dark
//   lz_suppress_in      : leading-zero suppression enable
//   brightness_in       : PWM level, 0 dimmest, all-ones full on
//   update_in           : load strobe for all display inputs
//   update_ack_out      : pulse when pending data becomes active
//   seg_out, dp_out     : segment {g..a} and decimal point drives
//   an_out              : anode enables
//   frame_tick_out      : pulse after each frame wrap
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 25000,
    parameter int BRIGHT_BITS = 3,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress_in,
    input  logic [BRIGHT_BITS-1:0]  brightness_in,
    input  logic                    update_in,
    output logic                    update_ack_out,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick_out
);

    localparam int   SW   = (clog2(REFRESH_DIV) < 1) ? 1 : clog2(REFRESH_DIV);
    localparam int   DW   = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int   MW   = BRIGHT_BITS + SW + 1;
    localparam int   UNIT = REFRESH_DIV >> BRIGHT_BITS;
    localparam logic INV  = (ACTIVE_LOW != 0);

    if (!params_legal(NUM_DIGITS, REFRESH_DIV, BRIGHT_BITS)) begin : g_param_check
        $error("seg_scan_driver: illegal NUM_DIGITS/REFRESH_DIV/BRIGHT_BITS");
    end

    logic [SW-1:0] slot_cnt;
    logic [DW-1:0] digit_idx;
    logic          slot_end;
    logic          wrap;

    logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
    logic                    pend_lz, act_lz;
    logic [BRIGHT_BITS-1:0]  pend_bright, act_bright;
    logic                    pend_valid;

    assign slot_end = (slot_cnt == SW'(REFRESH_DIV - 1));
    assign wrap     = slot_end && (digit_idx == DW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
        end
    end

    // The wrap transfer reads pending before this edge; a strobe on the same
    // cycle reloads pending and keeps pend_valid set for the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_digits    <= '0;
            pend_dp        <= '0;
            pend_blank     <= '0;
            pend_lz        <= 1'b0;
            pend_bright    <= '0;
            pend_valid     <= 1'b0;
            act_digits     <= '0;
            act_dp         <= '0;
            act_blank      <= '0;
            act_lz         <= 1'b0;
            act_bright     <= '0;
            update_ack_out <= 1'b0;
            frame_tick_out <= 1'b0;
        end else begin
            if (wrap && pend_valid) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
                act_lz     <= pend_lz;
                act_bright <= pend_bright;
            end
            if (update_in) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_blank  <= blank_in;
                pend_lz     <= lz_suppress_in;
                pend_bright <= brightness_in;
                pend_valid  <= 1'b1;
            end else if (wrap) begin
                pend_valid  <= 1'b0;
            end
            update_ack_out <= wrap && pend_valid;
            frame_tick_out <= wrap;
        end
    end

    // Leading-zero run is taken on raw digit values, so blanking does not end it.
    logic [NUM_DIGITS-1:0] suppress;
    logic                  zero_run;

    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_digits[4*i +: 4] == 4'h0);
            if (i != 0) suppress[i] = act_lz && zero_run;
        end
    end

    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic       cur_visible;

    always_comb begin
        cur_nibble  = 4'h0;
        cur_dp      = 1'b0;
        cur_visible = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == DW'(i)) begin
                cur_nibble  = act_digits[4*i +: 4];
                cur_dp      = act_dp[i];
                cur_visible = !act_blank[i] && !suppress[i];
            end
        end
    end

    logic [6:0] dec_seg;

    seg_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Slot 0 is always dark so anode hand-over never overlaps two digits.
    logic [MW-1:0]         on_len;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    assign on_len  = (MW'(act_bright) + MW'(1)) * MW'(UNIT);
    assign lit     = cur_visible && (slot_cnt != '0) && (MW'(slot_cnt) < on_len);
    assign an_nxt  = lit ? (NUM_DIGITS'(1) << digit_idx) : '0;
    assign seg_nxt = lit ? dec_seg : 7'h00;
    assign dp_nxt  = lit && cur_dp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_out  <= {NUM_DIGITS{INV}};
            seg_out <= {7{INV}};
            dp_out  <= INV;
        end else begin
            an_out  <= an_nxt ^ {NUM_DIGITS{INV}};
            seg_out <= seg_nxt ^ {7{INV}};
            dp_out  <= dp_nxt ^ INV;
        end
    end

endmodule
